mtr_drv: RTL and testbench
==========================

# mtr_drv

Dual-channel motor drive stage that converts signed left/right wheel speed commands into the four non-overlapping 11-bit PWM signals (`lftPWM1/2`, `rghtPWM1/2`) that drive the H-bridges. It sits between the navigation/PID controller and the motor bridges. In simulation these outputs feed the Knight physics model's inverse-PWM decoders directly.
- Both sides share one free-running 2048-clock period counter.
- Duty is double-buffered at the period boundary.
- Dead-time (non-overlap) is guaranteed between the two legs of each bridge.

## Interface
- `NONOVERLAP`, default 11'h020: dead-time in clocks, inserted before each leg turns on.
- `clk` input 1: 50 MHz system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `lft_spd` input 11, signed: left wheel speed command, range −1024..+1023.
- `rght_spd` input 11, signed: right wheel speed command, range −1024..+1023.
- `mtr_en` input 1: when low, all four PWM outputs are forced low (coast).
- `lftPWM1` output 1: left bridge, forward leg.
- `lftPWM2` output 1: left bridge, reverse leg.
- `rghtPWM1` output 1: right bridge, forward leg.
- `rghtPWM2` output 1: right bridge, reverse leg.
- `prd_start` output 1: one-clock pulse that is high in the cycle where `cnt`==0.

## Operation
- **Speed to duty.** Duty is computed per side as `duty = spd + 0x400`.
  - Implemented as `{~spd[10], spd[9:0]}`, an 11-bit unsigned value, range 0..2047.
  - No saturation is needed: the full signed range maps exactly onto the duty range.
  - spd=0 gives 50% (0x400).
- **Period counter.** `cnt` is 11 bits, increments every clk, and wraps 2047→0. The period is 2048 clocks.
- **Duty latch.**
  - `duty_lat` for each side loads the freshly mapped duty in the clock where `cnt`==2047, so it takes effect from `cnt`==0.
  - Speed changes mid-period have no effect until the next period.
- **Per-side next-state values.**
  - `PWM1_nxt` = mtr_en & (cnt ≥ NONOVERLAP) & (cnt < duty_lat).
  - `PWM2_nxt` = mtr_en & ({1'b0,cnt} ≥ {1'b0,duty_lat}+NONOVERLAP).
  - The PWM2 compare uses a 12-bit sum, so a sum above 2047 means PWM2 never asserts. No wrap.
- **High times per period.**
  - PWM1 is high for max(0, duty−NONOVERLAP) clocks.
  - PWM2 is high for max(0, 2048−duty−NONOVERLAP) clocks.
  - PWM1 and PWM2 of the same side are never high in the same clock.
  - Each leg turns on only after at least NONOVERLAP low clocks following the other leg's turn-off. This holds across the period wrap because PWM2 drops at `cnt`==0 and PWM1 rises no earlier than `cnt`==NONOVERLAP.
- **Coast.** `mtr_en` low forces all outputs low on the next clock. The counter and duty latches keep running.
- **Reset values.**
  - `cnt`=0, both `duty_lat`=0x400.
  - All four PWM outputs = 0, `prd_start` = 0.
- **Reset mid-period.** All outputs go low immediately (asynchronously). After release, the counter restarts at 0 with 50% duty until the first latch at `cnt`==2047.

## Timing
- All outputs are registered.
  - A PWM output in cycle t+1 reflects `cnt`, `duty_lat` and `mtr_en` sampled in cycle t.
  - `prd_start` is registered from (`cnt`==2047), so it is high in the cycle where `cnt`==0.
- **Command latency.** A speed change is reflected in the PWM outputs between 1 and 2048 clocks later, always starting at a period boundary.
- **Glitch-free.** No output toggles more than twice per period.

## Structure
- **Package `knight_pkg`.**
  - Holds `PWM_PERIOD`=2048, `DUTY_MID`=11'h400 and the default `NONOVERLAP` constant.
  - Holds the `spd_t` typedef (logic signed [10:0]).
- **Sub-module `pwm11_no`.**
  - Contents: one side's duty latch and compare/registered outputs.
  - Inputs: `cnt`, `duty`, `mtr_en`, and a latch strobe.
  - `mtr_drv` instantiates it twice alongside the shared counter.

## Test plan
1. **Zero speed.** lft_spd=rght_spd=0, mtr_en=1, NONOVERLAP=32 → each PWM1 and PWM2 high for 992 clocks per period. Inverse-PWM measures duty1−duty2=0, and there is no cycle with PWM1&PWM2.
2. **Full forward.** lft_spd=+1023 → lftPWM1 high 2015 clocks per period, lftPWM2 never high. rght_spd=+512 → rghtPWM1 high 1504 clocks, rghtPWM2 high 480 clocks.
3. **Full reverse.** lft_spd=−1024 → lftPWM1 never high. lftPWM2 high for `cnt` 32..2047, i.e. 2016 clocks, and low for ≥32 clocks at each wrap.
4. **Mid-period change.** Change lft_spd from 0 to +300 at cnt=500 → current period unchanged (PWM1 falls at cnt=1024). Next period PWM1 falls at cnt=1324 and PWM2 rises at cnt=1356. `prd_start` pulses once per 2048 clocks.
5. **Coast.** mtr_en low at cnt=200 → all outputs low next clock. Re-raise at cnt=900 with spd=0 → lftPWM1 high again next clock until cnt=1024.
6. **Reset mid-operation.** Assert rst_n low while PWM1=1 → outputs 0 immediately. After release, the first period runs at 50% duty regardless of spd, and the commanded duty applies from the second period.

Source files
------------

// File: rtl/knight_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : knight_pkg
//  Description : Shared constants, speed type and speed-to-duty mapping for
//                the dual-channel motor drive stage.
//                Contents: PWM_PERIOD, DUTY_MID, NONOVERLAP_DFLT, spd_t,
//                spd2duty().
//  Revision    : 1.0  initial release
// ============================================================================
package knight_pkg;

    localparam int          PWM_PERIOD      = 2048;
    localparam logic [10:0] DUTY_MID        = 11'h400;
    localparam logic [10:0] NONOVERLAP_DFLT = 11'h020;

    typedef logic signed [10:0] spd_t;

    // spd + 0x400 on an 11-bit signed value is just an MSB flip: -1024..+1023
    // maps exactly onto 0..2047, so no saturation is needed.
    function automatic logic [10:0] spd2duty(input spd_t spd);
        return {~spd[10], spd[9:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtr_drv_if.sv
`default_nettype none
// ============================================================================
//  Module      : mtr_drv_if
//  Description : Command / bridge-drive bundle between the speed controller
//                and the motor drive stage.
//                lft_spd, rght_spd : signed wheel speed commands
//                mtr_en            : drive enable (low = coast)
//                lftPWM1/2         : left bridge forward / reverse legs
//                rghtPWM1/2        : right bridge forward / reverse legs
//                prd_start         : PWM period start pulse
//                master = controller side, slave = drive stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface mtr_drv_if;
    import knight_pkg::*;

    spd_t lft_spd;
    spd_t rght_spd;
    logic mtr_en;
    logic lftPWM1;
    logic lftPWM2;
    logic rghtPWM1;
    logic rghtPWM2;
    logic prd_start;

    modport master (
        output lft_spd, rght_spd, mtr_en,
        input  lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_start
    );

    modport slave (
        input  lft_spd, rght_spd, mtr_en,
        output lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_start
    );

endinterface
`default_nettype wire

// File: rtl/mtr_drv_pwm11_no.sv
`default_nettype none
// ============================================================================
//  Module      : pwm11_no
//  Description : One bridge side: period-boundary duty latch plus the two
//                non-overlapping registered PWM legs.
//                clk, rst_n : clock, async active-low reset
//                cnt_i      : shared 11-bit period counter
//                duty_i     : freshly mapped duty (0..2047)
//                mtr_en_i   : drive enable, low forces both legs low
//                lat_i      : latch strobe, high in the cnt==2047 clock
//                pwm1_o     : forward leg
//                pwm2_o     : reverse leg
//  Revision    : 1.0  initial release
// ============================================================================
module pwm11_no
    import knight_pkg::*;
#(
    parameter logic [10:0] NONOVERLAP = NONOVERLAP_DFLT
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [10:0] cnt_i,
    input  wire logic [10:0] duty_i,
    input  wire logic        mtr_en_i,
    input  wire logic        lat_i,
    output logic             pwm1_o,
    output logic             pwm2_o
);

    logic [10:0] duty_lat_q, duty_lat_d;
    logic        pwm1_q, pwm1_d;
    logic        pwm2_q, pwm2_d;
    logic [11:0] pwm2_thr;

    // 12-bit threshold: a sum beyond 2047 can never be reached by cnt, so
    // the reverse leg simply stays off instead of wrapping to early in the period.
    assign pwm2_thr = {1'b0, duty_lat_q} + {1'b0, NONOVERLAP};

    always_comb begin
        duty_lat_d = lat_i ? duty_i : duty_lat_q;
        pwm1_d     = mtr_en_i && (cnt_i >= NONOVERLAP) && (cnt_i < duty_lat_q);
        pwm2_d     = mtr_en_i && ({1'b0, cnt_i} >= pwm2_thr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_lat_q <= DUTY_MID;
            pwm1_q     <= 1'b0;
            pwm2_q     <= 1'b0;
        end else begin
            duty_lat_q <= duty_lat_d;
            pwm1_q     <= pwm1_d;
            pwm2_q     <= pwm2_d;
        end
    end

    assign pwm1_o = pwm1_q;
    assign pwm2_o = pwm2_q;

endmodule
`default_nettype wire

// File: rtl/mtr_drv.sv
`default_nettype none
// ============================================================================
//  Module      : mtr_drv
//  Description : Dual-channel motor drive stage. Converts signed left/right
//                speed commands into four non-overlapping 11-bit PWM legs
//                sharing one free-running 2048-clock period counter.
//                clk   : system clock
//                rst_n : async active-low reset
//                bus   : mtr_drv_if.slave (speed commands in, PWM legs and
//                        prd_start out)
//  Revision    : 1.0  initial release
// ============================================================================
module mtr_drv
    import knight_pkg::*;
#(
    parameter logic [10:0] NONOVERLAP = NONOVERLAP_DFLT
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mtr_drv_if.slave  bus
);

    logic [10:0] cnt_q, cnt_d;
    logic        prd_start_q, prd_start_d;
    logic        last_clk;
    logic [10:0] lft_duty;
    logic [10:0] rght_duty;

    assign last_clk  = (cnt_q == 11'h7FF);
    assign lft_duty  = spd2duty(bus.lft_spd);
    assign rght_duty = spd2duty(bus.rght_spd);

    always_comb begin
        cnt_d       = cnt_q + 11'd1;   // natural 11-bit wrap 2047 -> 0
        prd_start_d = last_clk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 11'd0;
            prd_start_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            prd_start_q <= prd_start_d;
        end
    end

    assign bus.prd_start = prd_start_q;

    pwm11_no #(
        .NONOVERLAP (NONOVERLAP)
    ) u_lft (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_i    (cnt_q),
        .duty_i   (lft_duty),
        .mtr_en_i (bus.mtr_en),
        .lat_i    (last_clk),
        .pwm1_o   (bus.lftPWM1),
        .pwm2_o   (bus.lftPWM2)
    );

    pwm11_no #(
        .NONOVERLAP (NONOVERLAP)
    ) u_rght (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_i    (cnt_q),
        .duty_i   (rght_duty),
        .mtr_en_i (bus.mtr_en),
        .lat_i    (last_clk),
        .pwm1_o   (bus.rghtPWM1),
        .pwm2_o   (bus.rghtPWM2)
    );

endmodule
`default_nettype wire

// File: tb/tb_mtr_drv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mtr_drv
//  Description : Self-checking bench for mtr_drv. A cycle model derived from
//                the period/duty rules predicts every output; per-period high
//                times are also checked against the closed-form duty formulas.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mtr_drv;
    import knight_pkg::*;

    localparam int NO = 32;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    mtr_drv_if bus ();

    mtr_drv #(
        .NONOVERLAP (11'h020)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // At each falling edge the inputs equal what the preceding rising edge
    // sampled (stimulus only moves 2 time units after a falling edge).
    int mcnt;              // counter value sampled at the last rising edge
    int dl_l, dl_r;        // duty in force for the current period
    int win_l, win_r;      // duty in force over the window being accumulated
    int c_l1, c_l2, c_r1, c_r2, c_ovl;
    bit dirty;

    initial begin
        mcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mcnt  = 0;
                dl_l  = 1024;  dl_r  = 1024;
                win_l = 1024;  win_r = 1024;
                c_l1 = 0; c_l2 = 0; c_r1 = 0; c_r2 = 0; c_ovl = 0;
                dirty = 1'b0;
                check("rst_outs", {28'd0, bus.lftPWM1, bus.lftPWM2, bus.rghtPWM1, bus.rghtPWM2}, 0);
                check("rst_ps", int'(bus.prd_start), 0);
            end else begin
                bit en, el1, el2, er1, er2, eps;
                en  = bus.mtr_en;
                el1 = en && (mcnt >= NO) && (mcnt < dl_l);
                el2 = en && (mcnt >= dl_l + NO);
                er1 = en && (mcnt >= NO) && (mcnt < dl_r);
                er2 = en && (mcnt >= dl_r + NO);
                eps = (mcnt == PWM_PERIOD - 1);
                if (eps) begin
                    dl_l = int'(bus.lft_spd) + 1024;
                    dl_r = int'(bus.rght_spd) + 1024;
                end
                mcnt = (mcnt + 1) % PWM_PERIOD;

                check("lftPWM1", int'(bus.lftPWM1), int'(el1));
                check("lftPWM2", int'(bus.lftPWM2), int'(el2));
                check("rghtPWM1", int'(bus.rghtPWM1), int'(er1));
                check("rghtPWM2", int'(bus.rghtPWM2), int'(er2));
                check("prd_start", int'(bus.prd_start), int'(eps));

                if (!en) dirty = 1'b1;
                c_l1  += int'(bus.lftPWM1);
                c_l2  += int'(bus.lftPWM2);
                c_r1  += int'(bus.rghtPWM1);
                c_r2  += int'(bus.rghtPWM2);
                c_ovl += int'(bus.lftPWM1 & bus.lftPWM2) + int'(bus.rghtPWM1 & bus.rghtPWM2);

                if (eps) begin
                    check("overlap", c_ovl, 0);
                    if (!dirty) begin
                        check("hi_l1", c_l1, (win_l > NO) ? win_l - NO : 0);
                        check("hi_l2", c_l2, (PWM_PERIOD - win_l > NO) ? PWM_PERIOD - win_l - NO : 0);
                        check("hi_r1", c_r1, (win_r > NO) ? win_r - NO : 0);
                        check("hi_r2", c_r2, (PWM_PERIOD - win_r > NO) ? PWM_PERIOD - win_r - NO : 0);
                    end
                    c_l1 = 0; c_l2 = 0; c_r1 = 0; c_r2 = 0; c_ovl = 0;
                    win_l = dl_l;  win_r = dl_r;
                    dirty = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Next rising edge will sample cnt == c.
    task automatic wait_cnt(input int c);
        int guard;
        guard = 0;
        while (mcnt != c && guard < 4096) begin
            wait_cyc(1);
            guard++;
        end
        if (mcnt != c) check("wait_cnt_timeout", mcnt, c);
    endtask

    task automatic set_spd(input int l, input int r);
        bus.lft_spd  = spd_t'(l);
        bus.rght_spd = spd_t'(r);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        set_spd(0, 0);
        bus.mtr_en = 1'b1;
        wait_cyc(4);
        rst_n = 1'b1;

        // zero speed: 992/992 per side
        wait_cyc(2 * PWM_PERIOD + 10);

        // full forward / partial forward
        set_spd(1023, 512);
        wait_cyc(2 * PWM_PERIOD);

        // full reverse
        set_spd(-1024, -300);
        wait_cyc(2 * PWM_PERIOD);

        // mid-period change at cnt 500
        set_spd(0, 0);
        wait_cyc(PWM_PERIOD);
        wait_cnt(500);
        set_spd(300, -1);
        wait_cyc(2 * PWM_PERIOD + 5);

        // coast window 200..900, speed 0
        set_spd(0, 0);
        wait_cyc(PWM_PERIOD);
        wait_cnt(200);
        bus.mtr_en = 1'b0;
        wait_cnt(900);
        bus.mtr_en = 1'b1;
        wait_cyc(2 * PWM_PERIOD);

        // asynchronous reset while the forward leg is high
        wait_cnt(600);
        set_spd(700, -700);
        @(posedge clk);
        #3;
        check("pre_rst_l1", int'(bus.lftPWM1), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_l1", int'(bus.lftPWM1), 0);
        check("async_rst_all", {28'd0, bus.lftPWM1, bus.lftPWM2, bus.rghtPWM1, bus.rghtPWM2}, 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3 * PWM_PERIOD);

        // randomized speeds, change points and short coasts
        for (int p = 0; p < 6; p++) begin
            wait_cyc(int'($urandom_range(1, PWM_PERIOD)));
            set_spd(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
            if ($urandom_range(0, 3) == 0) begin
                bus.mtr_en = 1'b0;
                wait_cyc(int'($urandom_range(1, 300)));
                bus.mtr_en = 1'b1;
            end
            wait_cyc(PWM_PERIOD);
        end
        wait_cyc(2 * PWM_PERIOD);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
